// File: rtl/stream_link_pkg.sv
// Shared types and sizing helpers for the stream_link traffic generator.
// The optional payload checker is enabled with STREAM_LINK_CHECK_EN.
package stream_link_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic {S_WAIT, S_VALID} src_state_e;
  typedef enum logic {K_WAIT, K_READY} snk_state_e;

  // Idle counter width: enough for the larger delay, never below one bit.
  function automatic int cnt_width(input int delay_a, input int delay_b);
    int max_delay;
    int w;
    max_delay = (delay_a > delay_b) ? delay_a : delay_b;
    w = $clog2(max_delay + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_link_sink.sv
// Sink side of the link: waits DELAY idle cycles, raises ready, captures the
// payload on a transfer and counts transfers; optional in-order checker.
module stream_link_sink
  import stream_link_pkg::*;
#(
  parameter int DELAY  = 2,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic [15:0]       rx_cnt_o
`ifdef STREAM_LINK_CHECK_EN
  ,
  output logic              err_o
`endif
);

  snk_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] rx_data_q;
  logic [15:0]       rx_cnt_q;
  logic              delay_done;
  logic              xfer;

  assign delay_done = (DELAY == 0) || (cnt_q == CNT_W'(DELAY - 1));
  assign xfer       = (state_q == K_READY) && valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= K_WAIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rx_data_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      case (state_q)
        K_WAIT: begin
          if (delay_done) begin
            state_q <= K_READY;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        K_READY: begin
          if (xfer) begin
            rx_data_q <= data_i;
            rx_cnt_q  <= rx_cnt_q + 16'd1;
            cnt_q     <= '0;
            if (DELAY != 0) begin
              state_q <= K_WAIT;
              ready_q <= 1'b0;
            end
          end
        end
        default: state_q <= K_WAIT;
      endcase
    end
  end

`ifdef STREAM_LINK_CHECK_EN
  logic [DATA_W-1:0] exp_q;
  logic              err_q;

  // The first payload after reset is always 1, so the expectation starts there.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_q <= DATA_W'(1);
      err_q <= 1'b0;
    end else if (xfer) begin
      exp_q <= exp_q + DATA_W'(1);
      if (data_i != exp_q) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

  assign ready_o   = ready_q;
  assign rx_data_o = rx_data_q;
  assign rx_cnt_o  = rx_cnt_q;

endmodule

// File: rtl/stream_link_source.sv
// Source side of the link: waits DELAY idle cycles, then offers the next
// value of an incrementing sequence and holds it until the sink accepts.
module stream_link_source
  import stream_link_pkg::*;
#(
  parameter int DELAY  = 4,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  src_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              delay_done;

  assign delay_done = (DELAY == 0) || (cnt_q == CNT_W'(DELAY - 1));

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (delay_done) begin
            state_q <= S_VALID;
            valid_q <= 1'b1;
            data_q  <= data_q + DATA_W'(1);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_VALID: begin
          if (ready_i) begin
            cnt_q <= '0;
            // With no idle delay the next offer starts on the transfer edge.
            if (DELAY == 0) begin
              data_q <= data_q + DATA_W'(1);
            end else begin
              state_q <= S_WAIT;
              valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_link.sv
// Point-to-point valid/ready link with every link signal exported.
// Define STREAM_LINK_CHECK_EN to add the err_o payload-order checker.
module stream_link
  import stream_link_pkg::*;
#(
  parameter int DELAY_SOURCE = 4,
  parameter int DELAY_SINK   = 2,
  parameter int DATA_W       = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              valid_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic [15:0]       rx_cnt_o
`ifdef STREAM_LINK_CHECK_EN
  ,
  output logic              err_o
`endif
);

  localparam int CNT_W = cnt_width(DELAY_SOURCE, DELAY_SINK);

  logic              link_valid;
  logic              link_ready;
  logic [DATA_W-1:0] link_data;

  stream_link_source #(
    .DELAY (DELAY_SOURCE),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_source (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ready_i(link_ready),
    .valid_o(link_valid),
    .data_o (link_data)
  );

  stream_link_sink #(
    .DELAY (DELAY_SINK),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_sink (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (link_valid),
    .data_i   (link_data),
    .ready_o  (link_ready),
    .rx_data_o(rx_data_o),
    .rx_cnt_o (rx_cnt_o)
`ifdef STREAM_LINK_CHECK_EN
    ,
    .err_o    (err_o)
`endif
  );

  assign valid_o = link_valid;
  assign ready_o = link_ready;
  assign data_o  = link_data;

endmodule

// File: tb/tb_stream_link.sv
// Directed bench for stream_link: default, swapped and zero delays, reset
// mid-offer, and the optional checker when STREAM_LINK_CHECK_EN is defined.
module tb_stream_link;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic       d_valid, d_ready;
  logic [7:0] d_data, d_rx;
  logic [15:0] d_cnt;
  logic       s_valid, s_ready;
  logic [7:0] s_data, s_rx;
  logic [15:0] s_cnt;
  logic       z_valid, z_ready;
  logic [7:0] z_data, z_rx;
  logic [15:0] z_cnt;
`ifdef STREAM_LINK_CHECK_EN
  logic d_err, s_err, z_err;
`endif

  stream_link #(.DELAY_SOURCE(4), .DELAY_SINK(2), .DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .valid_o(d_valid), .ready_o(d_ready),
    .data_o(d_data), .rx_data_o(d_rx), .rx_cnt_o(d_cnt)
`ifdef STREAM_LINK_CHECK_EN
    , .err_o(d_err)
`endif
  );

  stream_link #(.DELAY_SOURCE(2), .DELAY_SINK(5), .DATA_W(8)) dut_sw (
    .clk_i(clk), .rst_i(rst), .valid_o(s_valid), .ready_o(s_ready),
    .data_o(s_data), .rx_data_o(s_rx), .rx_cnt_o(s_cnt)
`ifdef STREAM_LINK_CHECK_EN
    , .err_o(s_err)
`endif
  );

  stream_link #(.DELAY_SOURCE(0), .DELAY_SINK(0), .DATA_W(8)) dut_z (
    .clk_i(clk), .rst_i(rst), .valid_o(z_valid), .ready_o(z_ready),
    .data_o(z_data), .rx_data_o(z_rx), .rx_cnt_o(z_cnt)
`ifdef STREAM_LINK_CHECK_EN
    , .err_o(z_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rst low just after the reset edge, so the next edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if ({d_valid, d_ready, d_data, d_rx, d_cnt} !== 34'd0) begin
      errors++;
      $display("FAIL reset_dflt got v=%b r=%b d=%0d rx=%0d cnt=%0d want all 0",
               d_valid, d_ready, d_data, d_rx, d_cnt);
    end
    checks++;
    if ({s_valid, s_ready, s_data, s_rx, s_cnt, z_valid, z_ready, z_data, z_rx, z_cnt} !== 68'd0) begin
      errors++;
      $display("FAIL reset_other got sw v=%b r=%b d=%0d z v=%b r=%b d=%0d want all 0",
               s_valid, s_ready, s_data, z_valid, z_ready, z_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    logic [7:0] exp8;
    do_reset();
    step(1);
    checks++;
    if (d_valid !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL dflt_edge1 got v=%b r=%b want v=0 r=0", d_valid, d_ready);
    end
    step(1);
    checks++;
    if (d_valid !== 1'b0 || d_ready !== 1'b1) begin
      errors++;
      $display("FAIL dflt_edge2 got v=%b r=%b want v=0 r=1", d_valid, d_ready);
    end
    step(2);
    checks++;
    if (d_valid !== 1'b1 || d_data !== 8'd1 || d_cnt !== 16'd0) begin
      errors++;
      $display("FAIL dflt_edge4 got v=%b d=%0d cnt=%0d want v=1 d=1 cnt=0", d_valid, d_data, d_cnt);
    end
    step(1);
    checks++;
    if (d_rx !== 8'd1 || d_cnt !== 16'd1 || d_valid !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL dflt_xfer1 got rx=%0d cnt=%0d v=%b r=%b want rx=1 cnt=1 v=0 r=0",
               d_rx, d_cnt, d_valid, d_ready);
    end
    for (int k = 2; k <= 256; k++) begin
      step(5);
      exp8 = k[7:0];
      checks++;
      if (d_data !== exp8 || d_rx !== exp8 || d_cnt !== k[15:0]) begin
        errors++;
        $display("FAIL dflt_period k=%0d got d=%0d rx=%0d cnt=%0d want d=%0d rx=%0d cnt=%0d",
                 k, d_data, d_rx, d_cnt, exp8, exp8, k);
      end
    end
  endtask

  task automatic test_swapped();
    do_reset();
    step(1);
    checks++;
    if (s_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL sw_edge1 got v=%b r=%b want v=0 r=0", s_valid, s_ready);
    end
    step(1);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 8'd1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL sw_edge2 got v=%b d=%0d r=%b want v=1 d=1 r=0", s_valid, s_data, s_ready);
    end
    for (int e = 3; e <= 4; e++) begin
      step(1);
      checks++;
      if (s_valid !== 1'b1 || s_data !== 8'd1 || s_ready !== 1'b0 || s_cnt !== 16'd0) begin
        errors++;
        $display("FAIL sw_stall edge=%0d got v=%b d=%0d r=%b cnt=%0d want v=1 d=1 r=0 cnt=0",
                 e, s_valid, s_data, s_ready, s_cnt);
      end
    end
    step(1);
    checks++;
    if (s_ready !== 1'b1 || s_valid !== 1'b1 || s_data !== 8'd1 || s_cnt !== 16'd0) begin
      errors++;
      $display("FAIL sw_edge5 got r=%b v=%b d=%0d cnt=%0d want r=1 v=1 d=1 cnt=0",
               s_ready, s_valid, s_data, s_cnt);
    end
    step(1);
    checks++;
    if (s_rx !== 8'd1 || s_cnt !== 16'd1 || s_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL sw_xfer1 got rx=%0d cnt=%0d v=%b r=%b want rx=1 cnt=1 v=0 r=0",
               s_rx, s_cnt, s_valid, s_ready);
    end
    step(5);
    checks++;
    if (s_cnt !== 16'd1 || s_valid !== 1'b1 || s_data !== 8'd2) begin
      errors++;
      $display("FAIL sw_edge11 got cnt=%0d v=%b d=%0d want cnt=1 v=1 d=2", s_cnt, s_valid, s_data);
    end
    step(1);
    checks++;
    if (s_rx !== 8'd2 || s_cnt !== 16'd2) begin
      errors++;
      $display("FAIL sw_xfer2 got rx=%0d cnt=%0d want rx=2 cnt=2", s_rx, s_cnt);
    end
  endtask

  task automatic test_zero_delay();
    do_reset();
    step(1);
    checks++;
    if (z_valid !== 1'b1 || z_ready !== 1'b1 || z_data !== 8'd1 || z_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_edge1 got v=%b r=%b d=%0d cnt=%0d want v=1 r=1 d=1 cnt=0",
               z_valid, z_ready, z_data, z_cnt);
    end
    for (int n = 2; n <= 12; n++) begin
      step(1);
      checks++;
      if (z_valid !== 1'b1 || z_ready !== 1'b1 || z_data !== n[7:0] ||
          z_rx !== 8'(n - 1) || z_cnt !== 16'(n - 1)) begin
        errors++;
        $display("FAIL zero_b2b edge=%0d got v=%b r=%b d=%0d rx=%0d cnt=%0d want v=1 r=1 d=%0d rx=%0d cnt=%0d",
                 n, z_valid, z_ready, z_data, z_rx, z_cnt, n, n - 1, n - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(34);
    checks++;
    if (d_valid !== 1'b1 || d_data !== 8'd7 || d_rx !== 8'd6) begin
      errors++;
      $display("FAIL mid_pre got v=%b d=%0d rx=%0d want v=1 d=7 rx=6", d_valid, d_data, d_rx);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if ({d_valid, d_ready, d_data, d_rx, d_cnt} !== 34'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%b d=%0d rx=%0d cnt=%0d want all 0",
               d_valid, d_ready, d_data, d_rx, d_cnt);
    end
    step(4);
    checks++;
    if (d_valid !== 1'b1 || d_data !== 8'd1) begin
      errors++;
      $display("FAIL mid_reoffer got v=%b d=%0d want v=1 d=1", d_valid, d_data);
    end
    step(1);
    checks++;
    if (d_rx !== 8'd1 || d_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_first_xfer got rx=%0d cnt=%0d want rx=1 cnt=1", d_rx, d_cnt);
    end
  endtask

`ifdef STREAM_LINK_CHECK_EN
  task automatic test_checker();
    do_reset();
    checks++;
    if (d_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_reset got err=%b want 0", d_err);
    end
    step(1500);
    checks++;
    if (d_err !== 1'b0 || d_cnt !== 16'd300) begin
      errors++;
      $display("FAIL chk_clean got err=%b cnt=%0d want err=0 cnt=300", d_err, d_cnt);
    end
    do_reset();
    step(14);
    force dut.link_data = 8'd9;
    step(1);
    release dut.link_data;
    checks++;
    if (d_err !== 1'b1 || d_cnt !== 16'd3) begin
      errors++;
      $display("FAIL chk_detect got err=%b cnt=%0d want err=1 cnt=3", d_err, d_cnt);
    end
    step(20);
    checks++;
    if (d_err !== 1'b1) begin
      errors++;
      $display("FAIL chk_sticky got err=%b want 1", d_err);
    end
    do_reset();
    checks++;
    if (d_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_clear got err=%b want 0", d_err);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_defaults();
    test_swapped();
    test_zero_delay();
    test_reset_mid();
`ifdef STREAM_LINK_CHECK_EN
    test_checker();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
